// File: rtl/counter_seq_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_seq_ctrl_if : requester + counter-datapath bundle | rev 1.0
// ---------------------------------------------------------------------------
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] start0;
  logic [WIDTH-1:0] term0;
  logic [WIDTH-1:0] start1;
  logic [WIDTH-1:0] term1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             err;
  logic             busy;
  logic             load;
  logic             enable;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] cout;

  modport master (
    output req, start0, term0, start1, term1, cout,
    input  gnt, done, err, busy, load, enable, data
  );

  modport slave (
    input  req, start0, term0, start1, term1, cout,
    output gnt, done, err, busy, load, enable, data
  );
endinterface
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_seq_ctrl : round-robin sequencer for a loadable up-counter | rev 1.0
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int MAX_RUN = 255
) (
  input  logic               clk,
  input  logic               reset,
  counter_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] RUN_LIMIT = WIDTH'(MAX_RUN);

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [1:0]       gnt_q, gnt_nxt;
  logic [1:0]       done_q, done_nxt;
  logic             err_q, err_nxt;
  logic [WIDTH-1:0] wd, wd_nxt;
  logic [WIDTH-1:0] start_q, start_nxt;
  logic [WIDTH-1:0] term_q, term_nxt;

  logic winner;
  logic at_term;
  logic wd_expired;
  logic req_held;

  // On a tie the requester that was not served last wins.
  assign winner     = (bus.req == 2'b11) ? ~last : bus.req[1];
  assign at_term    = (bus.cout == term_q);
  assign wd_expired = (wd == RUN_LIMIT);
  assign req_held   = |(bus.req & gnt_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      wd      <= '0;
      start_q <= '0;
      term_q  <= '0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      gnt_q   <= gnt_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      wd      <= wd_nxt;
      start_q <= start_nxt;
      term_q  <= term_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gnt_nxt   = gnt_q;
    done_nxt  = 2'b00;
    err_nxt   = 1'b0;
    wd_nxt    = wd;
    start_nxt = start_q;
    term_nxt  = term_q;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          start_nxt = winner ? bus.start1 : bus.start0;
          term_nxt  = winner ? bus.term1  : bus.term0;
          gnt_nxt   = winner ? 2'b10 : 2'b01;
          last_nxt  = winner;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        wd_nxt = '0;
        if (!req_held) begin
          gnt_nxt   = 2'b00;
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Withdrawal outranks completion: a dropped request never sees done.
        if (!req_held) begin
          gnt_nxt   = 2'b00;
          state_nxt = IDLE;
        end else if (at_term) begin
          done_nxt  = gnt_q;
          state_nxt = DONE;
        end else if (wd_expired) begin
          done_nxt  = gnt_q;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      DONE: begin
        gnt_nxt   = 2'b00;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = 2'b00;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.load   = (state == LOAD);
  assign bus.data   = (state == LOAD) ? start_q : '0;
  assign bus.enable = (state == RUN) && !at_term && !wd_expired;
  assign bus.busy   = (state != IDLE);
  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule
`default_nettype wire

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequences the 8-bit loadable up-counter datapath (load/enable/data in, cout out) for two requesters.
- Round-robin arbitration picks one requester, which is granted exclusive use of the counter.
- The block loads the granted start value, enables counting until cout reaches the granted terminal value, then returns a done pulse.
- A watchdog aborts runs that exceed a cycle budget and flags an error.

Parameters:
- WIDTH, 8, counter/data width in bits.
- MAX_RUN, 255, maximum enable cycles per job before watchdog abort; legal range 1..2^WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  per-requester job request; level, held until that requester's done or err pulse.
- start0  in  WIDTH  requester 0 start value, sampled at grant.
- term0  in  WIDTH  requester 0 terminal value, sampled at grant.
- start1  in  WIDTH  requester 1 start value, sampled at grant.
- term1  in  WIDTH  requester 1 terminal value, sampled at grant.
- gnt  out  2  one-hot grant; high from grant through the DONE cycle.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle watchdog-abort pulse, coincident with done of the aborted job.
- busy  out  1  high in any state other than IDLE.
- load  out  1  counter load strobe.
- enable  out  1  counter count-enable.
- data  out  WIDTH  counter load value.
- cout  in  WIDTH  counter current value. Counter contract: synchronous, load has priority over enable, increments mod 2^WIDTH.

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; gnt, done, err, busy, load, enable = 0; data = 0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Watchdog counter = 0; latched start/term = 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req bit is high, select the winner:
    - Only one bit high: that requester wins.
    - Both high: the requester != last wins.
  - At the clock edge: latch the winner's start/term, set gnt one-hot, update last=winner, go to LOAD.
  - No req high: stay in IDLE.
- LOAD (exactly 1 cycle):
  - load=1, data=latched start, enable=0.
  - Next state RUN; watchdog cleared.
- RUN:
  - cout == latched term: enable=0, go to DONE with err=0.
  - Otherwise: enable=1, watchdog increments.
  - Watchdog reaches MAX_RUN while cout != term: enable=0, go to DONE with err flagged.
  - Resulting enable count = (term - start) mod 2^WIDTH, capped at MAX_RUN.
  - start == term: zero enable cycles.
- DONE (exactly 1 cycle):
  - done[g]=1; err=1 if the job was aborted; gnt still high.
  - Next state IDLE; gnt clears.
  - A new grant is possible at the earliest in the cycle after DONE, so arbitration is never back-to-back within DONE.
- Requester withdrawal: if req[g] falls during LOAD or RUN, go to IDLE next cycle, enable=0, no done and no err. last is still updated.
- req[g] high during DONE: ignored. The requester must drop req the cycle after done; if it is still high in IDLE it is treated as a new request.
- Output decode:
  - load, enable, data, done, err are decoded from the state register plus the cout==term compare.
  - done and err are registered alongside the DONE state.
  - No combinational path from req to load/enable.
- Wrap-around: term < start is legal; the counter wraps through 2^WIDTH-1 to 0.
- Mid-operation reset: all outputs drop immediately (asynchronously); no done is issued for the interrupted job.

Test Plan:
- Single job: req=01, start0=10, term0=15 → gnt=01; load=1 for 1 cycle with data=10; enable=1 for exactly 5 cycles; done=01 for 1 cycle; err=0; busy falls after DONE.
- Tie arbitration: req=11 from reset, both jobs start=0 term=2 → requester 0 served first, then requester 1. Repeat with req=11 → order 0, 1 again (alternation holds).
- Wrap: start0=250, term0=4 → 10 enable cycles; cout sequence passes through 255 → 0; done=01.
- Zero-length and watchdog:
  - start1=term1=77 → load, 0 enable cycles, done=10.
  - With MAX_RUN=8, start1=0 term1=200 → exactly 8 enable cycles, then done=10 with err=1.
- Withdrawal: drop req[0] on the 3rd RUN cycle → enable=0 next cycle; no done; busy=0; a pending req[1] is granted next.
- Async reset mid-RUN: assert reset=0 between clock edges → enable, gnt, busy go to 0 without a clock edge. After release, req=11 grants requester 0.
